oet_sorter: RTL and testbench
=============================

Name: oet_sorter

Overview:
- Parametrised sequential sorter using odd-even transposition with one compare-exchange phase per clock.
- Three-phase flow: stream N words in (valid/ready), sort in place, stream N sorted words out (valid/ready).
- Sort direction is selectable per batch. Reports the SORT cycle count; exits early once the array is sorted.
- Shared sorting engine for datapath blocks that need real-time ordered batches with cycle-accurate latency.

Parameters:
- N, 8, number of elements per batch; legal N >= 2.
- W, 32, element width in bits; unsigned compare.
- CW, 32, width of the sort_cycles counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_data valid
- in_ready  output  1  sorter accepts in_data
- in_data  input  W  element in
- descending  input  1  sort order, sampled on the handshake of element 0; 1 = descending
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts out_data
- out_data  output  W  sorted element out
- out_last  output  1  marks element N-1 of the output batch
- busy  output  1  high in SORT and OUT
- sort_cycles  output  CW  SORT-state cycles of the last completed sort

Behaviour:
- Reset (rst_n low, async):
  - state=LOAD; wr_idx=0, rd_idx=0, phase counter=0.
  - mode=ascending; all N storage words=0.
  - sort_cycles=0; out_valid=0, out_last=0, busy=0, out_data=0.
  - in_ready is decoded from state, so it is 1 during and after reset.
- State LOAD:
  - in_ready=1.
  - On in_valid&&in_ready: mem[wr_idx]<=in_data, wr_idx++.
  - If wr_idx==0 at that handshake, latch descending into mode.
  - Handshake with wr_idx==N-1: next state SORT, wr_idx<=0, phase counter<=0.
- State SORT (in_ready=0, busy=1):
  - Each cycle performs one phase; the first phase is even.
  - Even phase compare-exchanges pairs (0,1),(2,3),...; odd phase compares pairs (1,2),(3,4),....
  - All pairs in a phase update simultaneously from the pre-phase values.
  - Exchange rule: ascending swaps when mem[k]>mem[k+1]; descending swaps when mem[k]<mem[k+1]. Equal values are never swapped.
  - Track a per-phase no-swap flag.
  - Leave SORT after the phase in which either condition holds:
    - the phase counter has reached N phases, or
    - two consecutive phases both made no swap.
  - On leaving SORT: sort_cycles<=phases executed (range 2..N); next state OUT; rd_idx<=0.
- State OUT (busy=1):
  - out_valid=1, out_data=mem[rd_idx], out_last=(rd_idx==N-1).
  - out_data is held stable while out_ready=0.
  - On out_valid&&out_ready: rd_idx++.
  - Handshake with out_last=1: next state LOAD, rd_idx<=0, out_valid deasserts next cycle, busy deasserts.
- Outside OUT, out_valid=0, out_last=0 and out_data=0.
- Latency: the first out_valid is asserted S+1 cycles after the last input handshake, where S=sort_cycles. No bubbles while out_ready stays high.
- sort_cycles holds its value until the next sort completes; it is not cleared on LOAD.
- in_valid outside LOAD is ignored; no data is stored.
- Reset mid-SORT or mid-OUT aborts the batch. All state returns to reset values and the partial batch is discarded.
- No simultaneous load and unload: a new batch is accepted only after out_last is consumed.
- Counter widths: wr_idx and rd_idx are $clog2(N) bits; the phase counter is $clog2(N+1) bits.

Test Plan:
- Ascending, N=8, load 8,7,6,5,4,3,2,1 with out_ready=1 -> output 1..8; out_last on 8; sort_cycles=8; first out_valid 9 cycles after last input.
- Ascending, already-sorted input 1..8 -> output 1..8; sort_cycles=2 (early exit).
- Descending=1 on element 0, input 3,9,1,7,5,2,8,4 -> output 9,8,7,5,4,3,2,1; a descending change after element 0 has no effect.
- Duplicates, input 5,5,0,FFFFFFFF,5,0,1,1 ascending -> output 0,0,1,1,5,5,5,FFFFFFFF; unsigned compare confirmed.
- Backpressure: toggle out_ready 1,0,0,1,... during OUT -> out_data is stable while stalled; each element appears exactly once; in_ready stays 0 until out_last is consumed.
- Reset pulse in the 3rd SORT cycle -> out_valid=0, busy=0, in_ready=1, sort_cycles=0. The next full batch of 8..1 sorts correctly with sort_cycles=8.

Source files
------------

// File: rtl/oet_sorter.sv
// Sequential odd-even transposition sorter: stream N words in, sort one
// compare-exchange phase per clock with early exit, stream N words out.
module oet_sorter #(
  parameter int unsigned N  = 8,
  parameter int unsigned W  = 32,
  parameter int unsigned CW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          descending,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic          out_last,
  output logic          busy,
  output logic [CW-1:0] sort_cycles
);

  localparam int unsigned AW = $clog2(N);
  localparam int unsigned PW = $clog2(N + 1);

  typedef enum logic [1:0] {S_LOAD, S_SORT, S_OUT} state_t;

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_wr_idx, r_rd_idx;
  logic [PW-1:0] r_phase, w_phase_nxt;
  logic          r_desc;
  logic          r_prev_noswap;
  logic [CW-1:0] r_sort_cycles;
  logic [W-1:0]  r_mem     [N];
  logic [W-1:0]  w_mem_nxt [N];
  logic          w_swapped;
  logic          w_sort_done;
  logic          w_in_hs, w_out_hs;
  logic          w_wr_last, w_rd_last;

  assign in_ready    = (r_state == S_LOAD);
  assign busy        = (r_state != S_LOAD);
  assign out_valid   = (r_state == S_OUT);
  assign w_rd_last   = (r_rd_idx == AW'(N - 1));
  assign w_wr_last   = (r_wr_idx == AW'(N - 1));
  assign out_last    = out_valid && w_rd_last;
  assign out_data    = out_valid ? r_mem[r_rd_idx] : '0;
  assign sort_cycles = r_sort_cycles;
  assign w_in_hs     = in_valid && in_ready;
  assign w_out_hs    = out_valid && out_ready;

  // One phase: pairs starting at even (phase even) or odd indices, all from pre-phase values
  always_comb begin
    w_mem_nxt = r_mem;
    w_swapped = 1'b0;
    for (int unsigned k = 0; k < N - 1; k++) begin
      if (k[0] == r_phase[0]) begin
        if (r_desc ? (r_mem[k] < r_mem[k+1]) : (r_mem[k] > r_mem[k+1])) begin
          w_mem_nxt[k]   = r_mem[k+1];
          w_mem_nxt[k+1] = r_mem[k];
          w_swapped      = 1'b1;
        end
      end
    end
  end

  assign w_phase_nxt = r_phase + PW'(1);
  assign w_sort_done = (w_phase_nxt == PW'(N)) || (!w_swapped && r_prev_noswap);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LOAD:  if (w_in_hs && w_wr_last) w_state_nxt = S_SORT;
      S_SORT:  if (w_sort_done)          w_state_nxt = S_OUT;
      S_OUT:   if (w_out_hs && w_rd_last) w_state_nxt = S_LOAD;
      default: w_state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_LOAD;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_idx      <= '0;
      r_rd_idx      <= '0;
      r_phase       <= '0;
      r_desc        <= 1'b0;
      r_prev_noswap <= 1'b0;
      r_sort_cycles <= '0;
      for (int unsigned i = 0; i < N; i++) r_mem[i] <= '0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_in_hs) begin
            r_mem[r_wr_idx] <= in_data;
            if (r_wr_idx == '0) r_desc <= descending;
            if (w_wr_last) begin
              r_wr_idx      <= '0;
              r_phase       <= '0;
              r_prev_noswap <= 1'b0;
            end else begin
              r_wr_idx <= r_wr_idx + AW'(1);
            end
          end
        end
        S_SORT: begin
          r_mem         <= w_mem_nxt;
          r_phase       <= w_phase_nxt;
          r_prev_noswap <= !w_swapped;
          if (w_sort_done) begin
            r_sort_cycles <= CW'(w_phase_nxt);
            r_rd_idx      <= '0;
          end
        end
        S_OUT: begin
          if (w_out_hs) begin
            if (w_rd_last) r_rd_idx <= '0;
            else           r_rd_idx <= r_rd_idx + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_oet_sorter.sv
// Directed bench for oet_sorter: table of batches plus backpressure and
// mid-sort reset sequences.
module tb_oet_sorter;

  localparam int unsigned N  = 8;
  localparam int unsigned W  = 32;
  localparam int unsigned CW = 32;

  typedef logic [N-1:0][W-1:0] batch_t;

  typedef struct {
    batch_t        din;
    logic          desc;
    batch_t        dexp;
    logic [CW-1:0] cyc;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          descending;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_last;
  logic          busy;
  logic [CW-1:0] sort_cycles;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  vec_t        vecs[5];

  oet_sorter #(.N(N), .W(W), .CW(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .descending  (descending),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .busy        (busy),
    .sort_cycles (sort_cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  function automatic batch_t pk8(input logic [W-1:0] a0, a1, a2, a3, a4, a5, a6, a7);
    return {a7, a6, a5, a4, a3, a2, a1, a0};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Drives one batch; descending is only meaningful on element 0, so the rest get the opposite
  task automatic load_batch(input batch_t din, input logic desc);
    for (int i = 0; i < int'(N); i++) begin
      in_valid   = 1'b1;
      in_data    = din[i];
      descending = (i == 0) ? desc : ~desc;
      @(posedge clk); #1;
    end
    in_valid   = 1'b0;
    in_data    = '0;
    descending = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int k;
    out_ready = 1'b1;
    load_batch(v.din, v.desc);
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) check({tag, "_busy_in_sort"}, {63'b0, busy}, 64'd1);
    end while (!out_valid && k < 40);
    check({tag, "_latency"}, 64'(k), 64'(v.cyc) + 64'd1);
    for (int i = 0; i < int'(N); i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("%s_valid%0d", tag, i), {63'b0, out_valid}, 64'd1);
      check($sformatf("%s_data%0d", tag, i), 64'(out_data), 64'(v.dexp[i]));
      check($sformatf("%s_last%0d", tag, i), {63'b0, out_last}, (i == int'(N) - 1) ? 64'd1 : 64'd0);
    end
    @(negedge clk);
    check({tag, "_valid_after"}, {63'b0, out_valid}, 64'd0);
    check({tag, "_busy_after"}, {63'b0, busy}, 64'd0);
    check({tag, "_ready_after"}, {63'b0, in_ready}, 64'd1);
    check({tag, "_sort_cycles"}, 64'(sort_cycles), 64'(v.cyc));
  endtask

  initial begin
    logic [3:0]   pat;
    logic [W-1:0] prev;
    logic         stalled;
    int           idx, cyc, k;

    vecs[0] = '{din: pk8(8, 7, 6, 5, 4, 3, 2, 1), desc: 1'b0,
                dexp: pk8(1, 2, 3, 4, 5, 6, 7, 8), cyc: 8};
    vecs[1] = '{din: pk8(1, 2, 3, 4, 5, 6, 7, 8), desc: 1'b0,
                dexp: pk8(1, 2, 3, 4, 5, 6, 7, 8), cyc: 2};
    vecs[2] = '{din: pk8(2, 1, 3, 4, 5, 6, 7, 8), desc: 1'b0,
                dexp: pk8(1, 2, 3, 4, 5, 6, 7, 8), cyc: 3};
    vecs[3] = '{din: pk8(3, 9, 1, 7, 5, 2, 8, 4), desc: 1'b1,
                dexp: pk8(9, 8, 7, 5, 4, 3, 2, 1), cyc: 8};
    vecs[4] = '{din: pk8(5, 5, 0, 32'hFFFF_FFFF, 5, 0, 1, 1), desc: 1'b0,
                dexp: pk8(0, 0, 1, 1, 5, 5, 5, 32'hFFFF_FFFF), cyc: 8};

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    descending = 1'b0;
    out_ready  = 1'b1;
    #3;
    check("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_out_last", {63'b0, out_last}, 64'd0);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_in_ready", {63'b0, in_ready}, 64'd1);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_sort_cycles", 64'(sort_cycles), 64'd0);
    #9;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 5; v++) run_vec(vecs[v], $sformatf("v%0d", v));

    // Backpressure with stray in_valid during OUT
    pat       = 4'b1001;
    out_ready = 1'b0;
    load_batch(vecs[0].din, 1'b0);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!out_valid && k < 40);
    check("bp_reach_out", {63'b0, out_valid}, 64'd1);
    @(posedge clk); #1;
    idx = 0; cyc = 0; stalled = 1'b0; prev = '0;
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    while (idx < int'(N) && cyc < 100) begin
      out_ready = pat[cyc % 4];
      @(negedge clk);
      check($sformatf("bp_valid_c%0d", cyc), {63'b0, out_valid}, 64'd1);
      check($sformatf("bp_in_ready_c%0d", cyc), {63'b0, in_ready}, 64'd0);
      if (stalled) check($sformatf("bp_stable_c%0d", cyc), 64'(out_data), 64'(prev));
      if (out_ready) begin
        check($sformatf("bp_data%0d", idx), 64'(out_data), 64'(vecs[0].dexp[idx]));
        check($sformatf("bp_last%0d", idx), {63'b0, out_last}, (idx == int'(N) - 1) ? 64'd1 : 64'd0);
        idx++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        prev    = out_data;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    check("bp_all_elements", 64'(idx), 64'(N));
    @(negedge clk);
    check("bp_valid_after", {63'b0, out_valid}, 64'd0);
    check("bp_ready_after", {63'b0, in_ready}, 64'd1);

    // Reset pulse in the third SORT cycle
    load_batch(vecs[3].din, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_busy_before_rst", {63'b0, busy}, 64'd1);
    rst_n = 1'b0;
    #2;
    check("mid_rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("mid_rst_busy", {63'b0, busy}, 64'd0);
    check("mid_rst_in_ready", {63'b0, in_ready}, 64'd1);
    check("mid_rst_sort_cycles", 64'(sort_cycles), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(vecs[0], "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
